// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter slice (package uart_pkg).
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LAUNCH     = 2'd1,
      WAIT_START = 2'd2,
      WAIT_DONE  = 2'd3
   } uart_arb_state_t;

   localparam int UART_DATA_W       = 8;
   localparam int UART_BUSY_TIMEOUT = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the UART TX arbiter: per-requester request/byte in,
// one-hot ack and last grant index out.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = UART_DATA_W
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        ack;
   logic [ID_W-1:0]           grant_id;

   modport master (
      output req,
      output req_data,
      input  ack,
      input  grant_id
   );

   modport slave (
      input  req,
      input  req_data,
      output ack,
      output grant_id
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker (module uart_rr_pick): first set request
// bit strictly after ptr, wrapping modulo NUM_REQ.
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               valid,
   output logic [ID_W-1:0]    idx
);

   // Scan ptr+1 .. ptr+NUM_REQ; the first hit wins, ptr itself is checked last
   always_comb begin
      int unsigned cand;
      logic [ID_W-1:0] cand_idx;
      cand     = 0;
      cand_idx = '0;
      valid    = 1'b0;
      idx      = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand     = (32'(ptr) + i) % 32'(NUM_REQ);
         cand_idx = ID_W'(cand);
         if (!valid && req[cand_idx]) begin
            valid = 1'b1;
            idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// sources. Optional busy-rise watchdog enabled by macro UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = UART_DATA_W,
   parameter int BUSY_TIMEOUT = UART_BUSY_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_arbiter_if.slave  bus,
   output logic              active,
   output logic [DATA_W-1:0] uart_tx_data,
   output logic              uart_tx_wr_en,
   input  logic              uart_tx_busy
`ifdef UART_ARB_TIMEOUT_EN
   ,
   output logic              timeout_err,
   input  logic              err_clr
`endif
);

   localparam int ID_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be 2..16");
   end
   if (BUSY_TIMEOUT < 2) begin : g_bad_timeout
      $error("uart_tx_arbiter: BUSY_TIMEOUT must be at least 2");
   end

   uart_arb_state_t    state;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    grant_id_q;
   logic [NUM_REQ-1:0] ack_q;
   logic               pick_valid;
   logic [ID_W-1:0]    pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   logic [TW-1:0] tcnt;
`endif

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req   (bus.req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign bus.ack      = ack_q;
   assign bus.grant_id = grant_id_q;

   // Arbitration FSM: pick and latch, one-cycle launch, then follow busy through a frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ptr           <= ID_W'(NUM_REQ - 1);
         ack_q         <= '0;
         grant_id_q    <= '0;
         uart_tx_data  <= '0;
         uart_tx_wr_en <= 1'b0;
         active        <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         tcnt          <= '0;
         timeout_err   <= 1'b0;
`endif
      end else begin
         ack_q         <= '0;
         uart_tx_wr_en <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         // Placed before the FSM so a same-cycle timeout set overrides the clear
         if (err_clr) timeout_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pick_valid && !uart_tx_busy) begin
                  // ack/wr_en are registered here so they appear in the LAUNCH cycle
                  uart_tx_data  <= bus.req_data[pick_idx*DATA_W +: DATA_W];
                  grant_id_q    <= pick_idx;
                  ack_q         <= NUM_REQ'(1) << pick_idx;
                  uart_tx_wr_en <= 1'b1;
                  active        <= 1'b1;
                  state         <= LAUNCH;
               end
            end
            LAUNCH: begin
               ptr   <= grant_id_q;
               state <= WAIT_START;
`ifdef UART_ARB_TIMEOUT_EN
               tcnt  <= TW'(1);
`endif
            end
            WAIT_START: begin
               if (uart_tx_busy) begin
                  state <= WAIT_DONE;
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (tcnt >= TW'(BUSY_TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  active      <= 1'b0;
                  state       <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
`endif
            end
            WAIT_DONE: begin
               if (!uart_tx_busy) begin
                  active <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               active <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter busy flag.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int FRAME   = 20;
   localparam int LIMIT   = 400;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              active;
   logic [DATA_W-1:0] uart_tx_data;
   logic              uart_tx_wr_en;
   logic              uart_tx_busy = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
   logic              timeout_err;
   logic              err_clr = 1'b0;
`endif

   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;

   logic              model_en = 1'b1;
   int unsigned       start_cnt = 0;
   int unsigned       frame_cnt = 0;
   logic [DATA_W-1:0] cur_byte = '0;
   logic [DATA_W-1:0] rx_log[$];

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .DATA_W       (DATA_W),
      .BUSY_TIMEOUT (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .active        (active),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_wr_en (uart_tx_wr_en),
      .uart_tx_busy  (uart_tx_busy)
`ifdef UART_ARB_TIMEOUT_EN
      ,
      .timeout_err   (timeout_err),
      .err_clr       (err_clr)
`endif
   );

   always #10 clk = ~clk;

   // Transmitter stand-in: busy rises 3 cycles after wr_en, lasts FRAME cycles, logs byte at end
   always @(posedge clk) begin
      if (rst) begin
         uart_tx_busy <= 1'b0;
         start_cnt    <= 0;
         frame_cnt    <= 0;
      end else if (model_en) begin
         if (uart_tx_wr_en) begin
            cur_byte  <= uart_tx_data;
            start_cnt <= 2;
         end else if (start_cnt != 0) begin
            start_cnt <= start_cnt - 1;
            if (start_cnt == 1) begin
               uart_tx_busy <= 1'b1;
               frame_cnt    <= FRAME;
            end
         end else if (uart_tx_busy) begin
            frame_cnt <= frame_cnt - 1;
            if (frame_cnt == 1) begin
               uart_tx_busy <= 1'b0;
               rx_log.push_back(cur_byte);
            end
         end
      end
   end

   task automatic wait_wr_en(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < LIMIT; i++) begin
         @(negedge clk);
         if (uart_tx_wr_en) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < LIMIT; i++) begin
         @(negedge clk);
         if (!active && !uart_tx_busy && start_cnt == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req = '0;
      bus.req_data = '0;
      repeat (3) @(negedge clk);
      total_cnt++; if (uart_tx_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", uart_tx_wr_en); else pass_cnt++;
      total_cnt++; if (bus.ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", bus.ack); else pass_cnt++;
      total_cnt++; if (uart_tx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", uart_tx_data); else pass_cnt++;
      total_cnt++; if (bus.grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); else pass_cnt++;
      total_cnt++; if (active !== 1'b0) $display("FAIL reset_active: got %b want 0", active); else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_byte();
      bit ok;
      rx_log.delete();
      bus.req_data = '0;
      bus.req_data[7:0] = 8'hA5;
      bus.req = 4'b0001;
      @(negedge clk);
      total_cnt++; if (uart_tx_wr_en !== 1'b1) $display("FAIL single_wr_en: got %b want 1", uart_tx_wr_en); else pass_cnt++;
      total_cnt++; if (bus.ack !== 4'b0001) $display("FAIL single_ack: got %b want 0001", bus.ack); else pass_cnt++;
      total_cnt++; if (bus.grant_id !== 2'd0) $display("FAIL single_grant_id: got %0d want 0", bus.grant_id); else pass_cnt++;
      total_cnt++; if (uart_tx_data !== 8'hA5) $display("FAIL single_data: got %h want a5", uart_tx_data); else pass_cnt++;
      total_cnt++; if (active !== 1'b1) $display("FAIL single_active: got %b want 1", active); else pass_cnt++;
      bus.req = '0;
      @(negedge clk);
      total_cnt++; if (uart_tx_wr_en !== 1'b0) $display("FAIL single_wr_en_pulse: got %b want 0", uart_tx_wr_en); else pass_cnt++;
      total_cnt++; if (bus.ack !== 4'b0000) $display("FAIL single_ack_pulse: got %b want 0000", bus.ack); else pass_cnt++;
      wait_idle(ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL single_idle_timeout: got %b want 1", ok); else pass_cnt++;
      total_cnt++; if (rx_log.size() != 1) $display("FAIL single_rx_count: got %0d want 1", rx_log.size()); else pass_cnt++;
      if (rx_log.size() == 1) begin
         total_cnt++; if (rx_log[0] !== 8'hA5) $display("FAIL single_rx_byte: got %h want a5", rx_log[0]); else pass_cnt++;
      end
   endtask

   task automatic test_round_robin();
      int unsigned exp_id[5]   = '{0, 1, 2, 3, 0};
      logic [7:0]  exp_byte[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      bit seen, ok;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rx_log.delete();
      bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_wr_en(seen);
         total_cnt++; if (seen !== 1'b1) $display("FAIL rr_launch_%0d: got no wr_en want wr_en", k); else pass_cnt++;
         total_cnt++; if (bus.grant_id !== 2'(exp_id[k])) $display("FAIL rr_grant_%0d: got %0d want %0d", k, bus.grant_id, exp_id[k]); else pass_cnt++;
         total_cnt++; if (uart_tx_data !== exp_byte[k]) $display("FAIL rr_data_%0d: got %h want %h", k, uart_tx_data, exp_byte[k]); else pass_cnt++;
         total_cnt++; if (bus.ack !== 4'(1 << exp_id[k])) $display("FAIL rr_ack_%0d: got %b want %b", k, bus.ack, 4'(1 << exp_id[k])); else pass_cnt++;
         // requester 0 keeps req up after its first ack as a fresh request
         if (k != 0) bus.req[exp_id[k]] = 1'b0;
      end
      wait_idle(ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL rr_idle_timeout: got %b want 1", ok); else pass_cnt++;
      total_cnt++; if (rx_log.size() != 5) $display("FAIL rr_rx_count: got %0d want 5", rx_log.size()); else pass_cnt++;
      for (int k = 0; k < 5 && k < rx_log.size(); k++) begin
         total_cnt++; if (rx_log[k] !== exp_byte[k]) $display("FAIL rr_rx_%0d: got %h want %h", k, rx_log[k], exp_byte[k]); else pass_cnt++;
      end
   endtask

   task automatic test_busy_holdoff();
      bit seen, ok, early;
      int n;
      rx_log.delete();
      bus.req_data = '0;
      bus.req_data[7:0] = 8'h5C;
      bus.req = 4'b0001;
      wait_wr_en(seen);
      total_cnt++; if (seen !== 1'b1) $display("FAIL hold_first_launch: got no wr_en want wr_en"); else pass_cnt++;
      bus.req = '0;
      n = 0;
      while (!uart_tx_busy && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      bus.req_data[23:16] = 8'h77;
      bus.req[2] = 1'b1;
      early = 1'b0;
      n = 0;
      while (uart_tx_busy && n < LIMIT) begin
         if (bus.ack !== 4'b0000 || uart_tx_wr_en !== 1'b0) early = 1'b1;
         @(negedge clk);
         n++;
      end
      total_cnt++; if (early !== 1'b0) $display("FAIL hold_no_ack_while_busy: got %b want 0", early); else pass_cnt++;
      total_cnt++; if (uart_tx_busy !== 1'b0) $display("FAIL hold_busy_fall_timeout: got %b want 0", uart_tx_busy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (uart_tx_wr_en !== 1'b0) $display("FAIL hold_gap_plus1: got %b want 0", uart_tx_wr_en); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (uart_tx_wr_en !== 1'b1) $display("FAIL hold_gap_plus2: got %b want 1", uart_tx_wr_en); else pass_cnt++;
      total_cnt++; if (bus.grant_id !== 2'd2) $display("FAIL hold_grant: got %0d want 2", bus.grant_id); else pass_cnt++;
      total_cnt++; if (uart_tx_data !== 8'h77) $display("FAIL hold_data: got %h want 77", uart_tx_data); else pass_cnt++;
      total_cnt++; if (bus.ack !== 4'b0100) $display("FAIL hold_ack: got %b want 0100", bus.ack); else pass_cnt++;
      bus.req = '0;
      wait_idle(ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL hold_idle_timeout: got %b want 1", ok); else pass_cnt++;
      total_cnt++; if (rx_log.size() != 2) $display("FAIL hold_rx_count: got %0d want 2", rx_log.size()); else pass_cnt++;
   endtask

   task automatic test_boundary();
      int unsigned exp_id[4]   = '{3, 1, 3, 1};
      logic [7:0]  exp_byte[4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
      bit seen, ok;
      rx_log.delete();
      bus.req_data = '0;
      bus.req_data[15:8]  = 8'hFF;
      bus.req_data[31:24] = 8'h00;
      bus.req = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         wait_wr_en(seen);
         total_cnt++; if (seen !== 1'b1) $display("FAIL bnd_launch_%0d: got no wr_en want wr_en", k); else pass_cnt++;
         total_cnt++; if (bus.grant_id !== 2'(exp_id[k])) $display("FAIL bnd_grant_%0d: got %0d want %0d", k, bus.grant_id, exp_id[k]); else pass_cnt++;
         total_cnt++; if (uart_tx_data !== exp_byte[k]) $display("FAIL bnd_data_%0d: got %h want %h", k, uart_tx_data, exp_byte[k]); else pass_cnt++;
         if (k == 0) begin
            bus.req_data[31:24] = 8'hFF;
            @(negedge clk);
            total_cnt++; if (uart_tx_data !== 8'h00) $display("FAIL bnd_post_ack_hold: got %h want 00", uart_tx_data); else pass_cnt++;
         end else if (k == 1) begin
            bus.req_data[15:8] = 8'h00;
         end else begin
            bus.req[exp_id[k]] = 1'b0;
         end
      end
      wait_idle(ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL bnd_idle_timeout: got %b want 1", ok); else pass_cnt++;
      total_cnt++; if (rx_log.size() != 4) $display("FAIL bnd_rx_count: got %0d want 4", rx_log.size()); else pass_cnt++;
      for (int k = 0; k < 4 && k < rx_log.size(); k++) begin
         total_cnt++; if (rx_log[k] !== exp_byte[k]) $display("FAIL bnd_rx_%0d: got %h want %h", k, rx_log[k], exp_byte[k]); else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_frame();
      bit seen, ok, bad;
      int n;
      rx_log.delete();
      bus.req_data = '0;
      bus.req_data[7:0] = 8'h5A;
      bus.req = 4'b0001;
      wait_wr_en(seen);
      total_cnt++; if (seen !== 1'b1) $display("FAIL rstmid_launch: got no wr_en want wr_en"); else pass_cnt++;
      bus.req = '0;
      n = 0;
      while (!uart_tx_busy && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      repeat (FRAME / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total_cnt++; if (active !== 1'b0) $display("FAIL rstmid_active: got %b want 0", active); else pass_cnt++;
      total_cnt++; if (uart_tx_data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", uart_tx_data); else pass_cnt++;
      total_cnt++; if (bus.grant_id !== 2'd0) $display("FAIL rstmid_grant_id: got %0d want 0", bus.grant_id); else pass_cnt++;
      total_cnt++; if (uart_tx_wr_en !== 1'b0) $display("FAIL rstmid_wr_en: got %b want 0", uart_tx_wr_en); else pass_cnt++;
      bad = 1'b0;
      repeat (5) begin
         if (bus.ack !== 4'b0000 || uart_tx_wr_en !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      total_cnt++; if (bad !== 1'b0) $display("FAIL rstmid_no_reack: got %b want 0", bad); else pass_cnt++;
      bus.req_data[15:8] = 8'hCB;
      bus.req = 4'b0010;
      wait_wr_en(seen);
      total_cnt++; if (seen !== 1'b1) $display("FAIL rstmid_relaunch: got no wr_en want wr_en"); else pass_cnt++;
      total_cnt++; if (bus.grant_id !== 2'd1) $display("FAIL rstmid_grant: got %0d want 1", bus.grant_id); else pass_cnt++;
      total_cnt++; if (uart_tx_data !== 8'hCB) $display("FAIL rstmid_newdata: got %h want cb", uart_tx_data); else pass_cnt++;
      bus.req = '0;
      wait_idle(ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL rstmid_idle_timeout: got %b want 1", ok); else pass_cnt++;
      total_cnt++; if (rx_log.size() != 1) $display("FAIL rstmid_rx_count: got %0d want 1", rx_log.size()); else pass_cnt++;
      if (rx_log.size() == 1) begin
         total_cnt++; if (rx_log[0] !== 8'hCB) $display("FAIL rstmid_rx_byte: got %h want cb", rx_log[0]); else pass_cnt++;
      end
   endtask

`ifdef UART_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit seen;
      model_en = 1'b0;
      bus.req_data = '0;
      bus.req_data[7:0] = 8'h3C;
      bus.req = 4'b0001;
      wait_wr_en(seen);
      total_cnt++; if (seen !== 1'b1) $display("FAIL to_launch: got no wr_en want wr_en"); else pass_cnt++;
      bus.req = '0;
      repeat (15) @(negedge clk);
      total_cnt++; if (timeout_err !== 1'b0) $display("FAIL to_early: got %b want 0", timeout_err); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (timeout_err !== 1'b1) $display("FAIL to_set: got %b want 1", timeout_err); else pass_cnt++;
      total_cnt++; if (active !== 1'b0) $display("FAIL to_idle: got %b want 0", active); else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++; if (timeout_err !== 1'b1) $display("FAIL to_sticky: got %b want 1", timeout_err); else pass_cnt++;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      total_cnt++; if (timeout_err !== 1'b0) $display("FAIL to_clear: got %b want 0", timeout_err); else pass_cnt++;
      model_en = 1'b1;
   endtask
`endif

   initial begin
      bus.req      = '0;
      bus.req_data = '0;
      test_reset();
      test_single_byte();
      test_round_robin();
      test_busy_holdoff();
      test_boundary();
      test_reset_mid_frame();
`ifdef UART_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
